// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the boot-time instruction memory loader.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    CNT_LO,
    CNT_HI,
    DATA,
    CSUM,
    DONE,
    ERR
  } state_t;

  localparam logic [7:0]  DEFAULT_SYNC_BYTE = 8'hA5;
  localparam int unsigned CNT_W             = 16;

  // States in which a start pulse re-arms the loader.
  function automatic logic accepts_start(input state_t s);
    return (s == IDLE) || (s == DONE) || (s == ERR);
  endfunction

endpackage

// File: rtl/imem_word_packer.sv
// Packs a little-endian byte stream into 32-bit words and keeps a running XOR checksum.
module imem_word_packer (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        byte_en,
  input  logic [7:0]  byte_in,
  output logic        word_last,
  output logic        word_valid,
  output logic [31:0] word,
  output logic [7:0]  csum
);

  logic [1:0]  lane;
  logic [23:0] partial;

  assign word_last = (lane == 2'd3);

  // Bytes enter at the top and shift down so the first byte ends in [7:0].
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lane       <= '0;
      partial    <= '0;
      word       <= '0;
      word_valid <= 1'b0;
      csum       <= '0;
    end else begin
      word_valid <= 1'b0;
      if (clear) begin
        lane    <= '0;
        partial <= '0;
        csum    <= '0;
      end else if (byte_en) begin
        lane    <= lane + 2'd1;
        csum    <= csum ^ byte_in;
        partial <= {byte_in, partial[23:8]};
        if (word_last) begin
          word       <= {byte_in, partial};
          word_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: receives a framed byte stream, writes words into instruction memory from
// address 0 upward and holds the core until a frame loads with a matching checksum.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned ADDR_W    = 10,
  parameter logic [7:0]  SYNC_BYTE = DEFAULT_SYNC_BYTE
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_wdata,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_err
);

  localparam logic [31:0] CAP = 32'(1) << ADDR_W;

  state_t           state;
  logic [7:0]       cnt_lo;
  logic [CNT_W-1:0] n_words;
  logic [CNT_W-1:0] word_idx;
  logic [CNT_W-1:0] word_next;
  logic [CNT_W-1:0] cnt_full;
  logic             hs;
  logic             clear;
  logic             byte_en;
  logic             word_last;
  logic [7:0]       csum;

  assign hs        = rx_valid & rx_ready;
  assign clear     = start & accepts_start(state);
  assign byte_en   = hs & (state == DATA);
  assign word_next = word_idx + CNT_W'(1);
  assign cnt_full  = {rx_data, cnt_lo};

  imem_word_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .clear      (clear),
    .byte_en    (byte_en),
    .byte_in    (rx_data),
    .word_last  (word_last),
    .word_valid (im_we),
    .word       (im_wdata),
    .csum       (csum)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      rx_ready  <= 1'b0;
      im_addr   <= '0;
      cpu_hold  <= 1'b1;
      load_done <= 1'b0;
      load_err  <= 1'b0;
      cnt_lo    <= '0;
      n_words   <= '0;
      word_idx  <= '0;
    end else begin
      case (state)
        IDLE, DONE, ERR: begin
          if (start) begin
            state     <= SYNC;
            rx_ready  <= 1'b1;
            cpu_hold  <= 1'b1;
            load_done <= 1'b0;
            load_err  <= 1'b0;
            word_idx  <= '0;
          end
        end
        SYNC: begin
          if (hs && rx_data == SYNC_BYTE) state <= CNT_LO;
        end
        CNT_LO: begin
          if (hs) begin
            cnt_lo <= rx_data;
            state  <= CNT_HI;
          end
        end
        CNT_HI: begin
          if (hs) begin
            n_words <= cnt_full;
            if (32'(cnt_full) > CAP) begin
              state    <= ERR;
              rx_ready <= 1'b0;
              load_err <= 1'b1;
            end else if (cnt_full == '0) begin
              state <= CSUM;
            end else begin
              state <= DATA;
            end
          end
        end
        DATA: begin
          // Address is registered alongside the packer's word pulse so both land in the same cycle.
          if (hs && word_last) begin
            im_addr  <= ADDR_W'(word_idx);
            word_idx <= word_next;
            if (word_next == n_words) state <= CSUM;
          end
        end
        CSUM: begin
          if (hs) begin
            rx_ready <= 1'b0;
            if (rx_data == csum) begin
              state     <= DONE;
              load_done <= 1'b1;
              cpu_hold  <= 1'b0;
            end else begin
              state    <= ERR;
              load_err <= 1'b1;
            end
          end
        end
        default: begin
          state    <= IDLE;
          rx_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: table of frames checked against a frame-level model.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        start4 = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;

  logic        rx_ready, im_we, cpu_hold, load_done, load_err;
  logic [9:0]  im_addr;
  logic [31:0] im_wdata;
  logic        rx_ready4, im_we4, cpu_hold4, load_done4, load_err4;
  logic [3:0]  im_addr4;
  logic [31:0] im_wdata4;

  always #5 clk = ~clk;

  imem_loader #(.ADDR_W(10), .SYNC_BYTE(8'hA5)) dut (
    .clk(clk), .rst(rst), .start(start), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_ready(rx_ready), .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata),
    .cpu_hold(cpu_hold), .load_done(load_done), .load_err(load_err)
  );

  imem_loader #(.ADDR_W(4), .SYNC_BYTE(8'hA5)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_ready(rx_ready4), .im_we(im_we4), .im_addr(im_addr4), .im_wdata(im_wdata4),
    .cpu_hold(cpu_hold4), .load_done(load_done4), .load_err(load_err4)
  );

  int passed = 0;
  int total  = 0;

  logic [47:0] wr_q[$];
  logic [47:0] wr4_q[$];

  always @(negedge clk) begin
    if (im_we)  wr_q.push_back({16'(im_addr), im_wdata});
    if (im_we4) wr4_q.push_back({16'(im_addr4), im_wdata4});
  end

  typedef struct {
    bit          sel;
    int          n;
    int          garbage;
    bit          gaps;
    bit          randw;
    logic [7:0]  flip;
    logic [31:0] w0;
    logic [31:0] w1;
    bit          exp_done;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic send_byte(input bit sel, input logic [7:0] b, input bit gaps, input bit st);
    bit ok = 1'b0;
    if (gaps) begin
      for (int g = 0; g < 4 && $urandom_range(2) == 0; g++) begin
        @(negedge clk);
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
        start    = 1'b0;
      end
    end
    for (int k = 0; k < 20 && !ok; k++) begin
      @(negedge clk);
      rx_valid = 1'b1;
      rx_data  = b;
      start    = st;
      ok       = sel ? rx_ready4 : rx_ready;
    end
    if (!ok) begin
      total++;
      $display("FAIL byte_accept: rx_ready stayed 0 while sending %02h", b);
    end
  endtask

  task automatic idle_bus();
    @(negedge clk);
    rx_valid = 1'b0;
    start    = 1'b0;
  endtask

  task automatic pulse_start(input bit sel);
    @(negedge clk);
    if (sel) start4 = 1'b1; else start = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    start4 = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    logic [31:0] words[$];
    logic [7:0]  gar[3];
    logic [7:0]  xsum;
    logic [7:0]  gb;
    logic [15:0] n16;
    logic [47:0] got[$];
    int          nchk;
    gar  = '{8'h00, 8'hFF, 8'h12};
    xsum = 8'h00;
    n16  = 16'(v.n);
    for (int i = 0; i < v.n; i++) begin
      if (v.randw) words.push_back($urandom);
      else         words.push_back(i == 0 ? v.w0 : v.w1);
      for (int k = 0; k < 4; k++) xsum ^= words[i][8*k +: 8];
    end
    if (v.sel) wr4_q.delete(); else wr_q.delete();
    pulse_start(v.sel);
    check({tag, "_hold_armed"}, 48'(v.sel ? cpu_hold4 : cpu_hold), 48'd1);
    check({tag, "_done_cleared"}, 48'(v.sel ? load_done4 : load_done), 48'd0);
    for (int g = 0; g < v.garbage; g++) begin
      if (g < 3) gb = gar[g];
      else begin
        gb = 8'($urandom);
        if (gb == 8'hA5) gb = 8'h5A;
      end
      send_byte(v.sel, gb, v.gaps, 1'b0);
    end
    send_byte(v.sel, 8'hA5, v.gaps, 1'b0);
    send_byte(v.sel, n16[7:0], v.gaps, 1'b0);
    send_byte(v.sel, n16[15:8], v.gaps, 1'b0);
    for (int i = 0; i < v.n; i++)
      for (int k = 0; k < 4; k++)
        send_byte(v.sel, words[i][8*k +: 8], v.gaps, v.gaps && i == 1 && k == 1);
    send_byte(v.sel, xsum ^ v.flip, v.gaps, 1'b0);
    idle_bus();
    repeat (3) @(negedge clk);
    check({tag, "_load_done"}, 48'(v.sel ? load_done4 : load_done), 48'(v.exp_done));
    check({tag, "_load_err"},  48'(v.sel ? load_err4 : load_err), 48'(!v.exp_done));
    check({tag, "_cpu_hold"},  48'(v.sel ? cpu_hold4 : cpu_hold), 48'(!v.exp_done));
    check({tag, "_rx_ready"},  48'(v.sel ? rx_ready4 : rx_ready), 48'd0);
    got = v.sel ? wr4_q : wr_q;
    check({tag, "_write_count"}, 48'(got.size()), 48'(v.n));
    nchk = (got.size() < v.n) ? got.size() : v.n;
    for (int i = 0; i < nchk; i++)
      check($sformatf("%s_write%0d", tag, i), got[i], {16'(i), words[i]});
  endtask

  initial begin
    vecs[0] = '{1'b0, 2, 0, 1'b0, 1'b0, 8'h00, 32'h13, 32'h6F, 1'b1};
    vecs[1] = '{1'b0, 2, 0, 1'b0, 1'b0, 8'h01, 32'h13, 32'h6F, 1'b0};
    vecs[2] = '{1'b0, 0, 3, 1'b0, 1'b0, 8'h00, 32'h0,  32'h0,  1'b1};
    vecs[3] = '{1'b0, 2, 0, 1'b1, 1'b0, 8'h00, 32'h13, 32'h6F, 1'b1};
    vecs[4] = '{1'b0, 7, 5, 1'b1, 1'b1, 8'h00, 32'h0,  32'h0,  1'b1};
    vecs[5] = '{1'b0, 5, 0, 1'b0, 1'b1, 8'h80, 32'h0,  32'h0,  1'b0};
    vecs[6] = '{1'b1, 16, 0, 1'b0, 1'b1, 8'h00, 32'h0, 32'h0,  1'b1};

    repeat (2) @(negedge clk);
    check("rst_rx_ready", 48'(rx_ready), 48'd0);
    check("rst_im_we", 48'(im_we), 48'd0);
    check("rst_im_addr", 48'(im_addr), 48'd0);
    check("rst_im_wdata", 48'(im_wdata), 48'd0);
    check("rst_cpu_hold", 48'(cpu_hold), 48'd1);
    check("rst_load_done", 48'(load_done), 48'd0);
    check("rst_load_err", 48'(load_err), 48'd0);
    rst = 1'b0;

    for (int i = 0; i < 7; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Oversized count on the 16-word instance must fail right after the count bytes.
    wr4_q.delete();
    pulse_start(1'b1);
    send_byte(1'b1, 8'hA5, 1'b0, 1'b0);
    send_byte(1'b1, 8'h11, 1'b0, 1'b0);
    send_byte(1'b1, 8'h00, 1'b0, 1'b0);
    idle_bus();
    repeat (2) @(negedge clk);
    check("big_n_err", 48'(load_err4), 48'd1);
    check("big_n_done", 48'(load_done4), 48'd0);
    check("big_n_rx_ready", 48'(rx_ready4), 48'd0);
    check("big_n_hold", 48'(cpu_hold4), 48'd1);
    check("big_n_writes", 48'(wr4_q.size()), 48'd0);

    // Reset in the middle of word 0.
    wr_q.delete();
    pulse_start(1'b0);
    send_byte(1'b0, 8'hA5, 1'b0, 1'b0);
    send_byte(1'b0, 8'h02, 1'b0, 1'b0);
    send_byte(1'b0, 8'h00, 1'b0, 1'b0);
    send_byte(1'b0, 8'h13, 1'b0, 1'b0);
    send_byte(1'b0, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    rx_valid = 1'b0;
    rst      = 1'b1;
    @(negedge clk);
    check("midrst_rx_ready", 48'(rx_ready), 48'd0);
    check("midrst_im_we", 48'(im_we), 48'd0);
    check("midrst_im_addr", 48'(im_addr), 48'd0);
    check("midrst_im_wdata", 48'(im_wdata), 48'd0);
    check("midrst_cpu_hold", 48'(cpu_hold), 48'd1);
    check("midrst_load_done", 48'(load_done), 48'd0);
    check("midrst_load_err", 48'(load_err), 48'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("midrst_no_write", 48'(wr_q.size()), 48'd0);
    run_vec(vecs[0], "after_rst");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit, got running expected finished");
    $fatal(1);
  end

endmodule
